pipe_ctrl: RTL and testbench
============================

// Module: pipe_ctrl
// PURPOSE
//  Pipeline sequencer for the 5-stage core. Collects hazard and stall requests
//  from ID, EX and MEM, and drives per-stage hold and bubble controls for the
//  PC, IF/ID, ID/EX, EX/MEM and MEM/WB registers, plus the PC redirect. Owns
//  load-use bubbles, multi-cycle EX ops (div) with timeout, and branch redirect
//  deferred across memory waits.
// PARAMETERS
//  ADDR_W      32  width of instruction address
//  MC_TIMEOUT  64  max cycles in MCWAIT before forced release (>=2)
// PORTS
//  clk              in   1       core clock
//  rst              in   1       reset: synchronous, active-high
//  id_ld_use_i      in   1       ID source reg matches load dest in EX
//  ex_mc_start_i    in   1       EX issues multi-cycle op this cycle
//  ex_mc_done_i     in   1       multi-cycle unit result valid
//  ex_branch_i      in   1       EX resolved taken branch/jump
//  ex_branch_addr_i in   ADDR_W  branch/jump target
//  mem_stall_i      in   1       data memory not ready
//  stall_o          out  5       hold: [0]PC [1]IF/ID [2]ID/EX [3]EX/MEM [4]MEM/WB
//  flush_ifid_o     out  1       load NOP into IF/ID
//  flush_idex_o     out  1       load bubble into ID/EX (wreg off, aluop NONE)
//  flush_exmem_o    out  1       load bubble into EX/MEM
//  new_pc_valid_o   out  1       PC takes new_pc_o this cycle
//  new_pc_o         out  ADDR_W  redirect target
//  mc_timeout_o     out  1       sticky: multi-cycle op timed out
//  state_o          out  2       FSM state (debug)
// BEHAVIOUR
//  - FSM states: RUN=0, LDUSE=1, MCWAIT=2. Regs: state, mc_cnt, br_pend,
//    br_addr, mc_timeout. Control outputs are combinational from state+inputs.
//  - Reset (rst=1 at posedge): state=RUN, mc_cnt=0, br_pend=0, br_addr=0,
//    mc_timeout_o=0. While rst=1: stall_o=0, all flush=0, new_pc_valid_o=0,
//    new_pc_o=0. Reset mid-MCWAIT abandons the op.
//  - Priority per cycle: mem_stall > MCWAIT/mc_start > branch > load-use.
//  - mem_stall_i=1 (any state): stall_o=01111, no flush, no redirect, no
//    state change, mc_cnt frozen. If ex_branch_i=1: br_pend<=1, br_addr<=target.
//  - RUN, ex_mc_start_i=1: stall_o=00111, flush_exmem_o=1, ->MCWAIT, mc_cnt<=0.
//    A branch in the same cycle is ignored (illegal combination).
//  - MCWAIT, done=0: stall_o=00111, flush_exmem_o=1, mc_cnt++. When
//    mc_cnt==MC_TIMEOUT-1: mc_timeout_o<=1 (sticky), ->RUN. Outputs in the
//    timeout cycle equal the done=0 values.
//  - MCWAIT, done=1: stall_o=0, no flush (EX/MEM captures result), ->RUN.
//  - RUN, branch (ex_branch_i or br_pend): new_pc_valid_o=1, flush_ifid_o=1,
//    flush_idex_o=1, stall_o=0. new_pc_o=br_addr if br_pend, else
//    ex_branch_addr_i. br_pend<=0. Load-use in the same cycle is ignored.
//  - RUN, id_ld_use_i only: stall_o=00011, flush_idex_o=1, ->LDUSE.
//  - LDUSE: exactly one bubble. id_ld_use_i ignored. Outputs as RUN without
//    load-use. Branch is honoured. ->RUN.
//  - Otherwise stall_o=0, flushes=0, new_pc_valid_o=0, new_pc_o=0.
//  - stall_o[4] is never set. A flush and a hold never target the same register.
// TESTING
//  1 rst=1 3 cycles in MCWAIT -> next cycle state_o=0, stall_o=0, timeout=0.
//  2 RUN, id_ld_use_i=1 for 2 cycles -> cycle0 stall=00011 flush_idex=1,
//    cycle1 stall=0 flush=0, state back to RUN.
//  3 mc_start, done after 5 cycles -> stall=00111 + flush_exmem for 5 cycles,
//    0 on done cycle; done never -> timeout=1 after 64 cycles, then RUN.
//  4 branch to 0x80 with mem_stall=1 for 3 cycles, ex_branch_addr_i changed to
//    0x0 on cycle 2 -> stall=01111 for 3 cycles; first free cycle
//    new_pc_valid=1, new_pc=0x80, flush_ifid=flush_idex=1.
//  5 branch 0x100 + id_ld_use_i same cycle -> redirect to 0x100,
//    stall_o=0, state stays RUN.

Source files
------------

// File: rtl/pipe_ctrl.sv
// +----------------------------------------------------------------------------+
// | Module      : pipe_ctrl                                                    |
// | Description : 5-stage pipeline sequencer: hold/bubble controls, load-use,  |
// |               multi-cycle EX wait with timeout, deferred branch redirect.  |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
`default_nettype none

module pipe_ctrl #(
  parameter int ADDR_W     = 32,
  parameter int MC_TIMEOUT = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              id_ld_use_i,
  input  logic              ex_mc_start_i,
  input  logic              ex_mc_done_i,
  input  logic              ex_branch_i,
  input  logic [ADDR_W-1:0] ex_branch_addr_i,
  input  logic              mem_stall_i,
  output logic [4:0]        stall_o,
  output logic              flush_ifid_o,
  output logic              flush_idex_o,
  output logic              flush_exmem_o,
  output logic              new_pc_valid_o,
  output logic [ADDR_W-1:0] new_pc_o,
  output logic              mc_timeout_o,
  output logic [1:0]        state_o
);

  localparam int CNT_W = $clog2(MC_TIMEOUT);

  localparam logic [CNT_W-1:0] c_cnt_last  = CNT_W'(MC_TIMEOUT - 1);
  localparam logic [4:0]       c_hold_mem  = 5'b01111;
  localparam logic [4:0]       c_hold_ex   = 5'b00111;
  localparam logic [4:0]       c_hold_id   = 5'b00011;

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_LDUSE  = 2'd1,
    ST_MCWAIT = 2'd2
  } state_t;

  state_t            r_state,  w_state_nxt;
  logic [CNT_W-1:0]  r_mc_cnt, w_mc_cnt_nxt;
  logic              r_br_pend, w_br_pend_nxt;
  logic [ADDR_W-1:0] r_br_addr, w_br_addr_nxt;
  logic              r_mc_timeout, w_mc_timeout_nxt;

  logic [4:0]        w_stall;
  logic              w_flush_ifid;
  logic              w_flush_idex;
  logic              w_flush_exmem;
  logic              w_pc_valid;
  logic [ADDR_W-1:0] w_new_pc;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= ST_RUN;
      r_mc_cnt     <= '0;
      r_br_pend    <= 1'b0;
      r_br_addr    <= '0;
      r_mc_timeout <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_mc_cnt     <= w_mc_cnt_nxt;
      r_br_pend    <= w_br_pend_nxt;
      r_br_addr    <= w_br_addr_nxt;
      r_mc_timeout <= w_mc_timeout_nxt;
    end
  end

  always_comb begin
    w_state_nxt      = r_state;
    w_mc_cnt_nxt     = r_mc_cnt;
    w_br_pend_nxt    = r_br_pend;
    w_br_addr_nxt    = r_br_addr;
    w_mc_timeout_nxt = r_mc_timeout;
    w_stall          = '0;
    w_flush_ifid     = 1'b0;
    w_flush_idex     = 1'b0;
    w_flush_exmem    = 1'b0;
    w_pc_valid       = 1'b0;
    w_new_pc         = '0;

    if (mem_stall_i) begin
      // A branch resolved while memory waits is remembered and replayed later.
      w_stall = c_hold_mem;
      if (ex_branch_i) begin
        w_br_pend_nxt = 1'b1;
        w_br_addr_nxt = ex_branch_addr_i;
      end
    end else if (r_state == ST_MCWAIT) begin
      if (ex_mc_done_i) begin
        w_state_nxt = ST_RUN;
      end else begin
        w_stall       = c_hold_ex;
        w_flush_exmem = 1'b1;
        w_mc_cnt_nxt  = r_mc_cnt + CNT_W'(1);
        if (r_mc_cnt == c_cnt_last) begin
          w_mc_timeout_nxt = 1'b1;
          w_state_nxt      = ST_RUN;
        end
      end
    end else if (ex_mc_start_i) begin
      w_stall       = c_hold_ex;
      w_flush_exmem = 1'b1;
      w_mc_cnt_nxt  = '0;
      w_state_nxt   = ST_MCWAIT;
    end else if (ex_branch_i || r_br_pend) begin
      w_pc_valid    = 1'b1;
      w_flush_ifid  = 1'b1;
      w_flush_idex  = 1'b1;
      w_new_pc      = r_br_pend ? r_br_addr : ex_branch_addr_i;
      w_br_pend_nxt = 1'b0;
      w_state_nxt   = ST_RUN;
    end else if (id_ld_use_i && (r_state == ST_RUN)) begin
      w_stall      = c_hold_id;
      w_flush_idex = 1'b1;
      w_state_nxt  = ST_LDUSE;
    end else begin
      w_state_nxt = ST_RUN;
    end
  end

  assign stall_o        = rst ? 5'b00000 : w_stall;
  assign flush_ifid_o   = ~rst & w_flush_ifid;
  assign flush_idex_o   = ~rst & w_flush_idex;
  assign flush_exmem_o  = ~rst & w_flush_exmem;
  assign new_pc_valid_o = ~rst & w_pc_valid;
  assign new_pc_o       = rst ? '0 : w_new_pc;
  assign mc_timeout_o   = r_mc_timeout;
  assign state_o        = r_state;

endmodule

`default_nettype wire

// File: tb/tb_pipe_ctrl.sv
// +----------------------------------------------------------------------------+
// | Module      : tb_pipe_ctrl                                                 |
// | Description : Directed and randomized checks of pipe_ctrl against a       |
// |               cycle-level reference model of the sequencing rules.        |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_pipe_ctrl;

  localparam int ADDR_W     = 32;
  localparam int MC_TIMEOUT = 64;

  logic              clk;
  logic              rst;
  logic              id_ld_use_i;
  logic              ex_mc_start_i;
  logic              ex_mc_done_i;
  logic              ex_branch_i;
  logic [ADDR_W-1:0] ex_branch_addr_i;
  logic              mem_stall_i;
  logic [4:0]        stall_o;
  logic              flush_ifid_o;
  logic              flush_idex_o;
  logic              flush_exmem_o;
  logic              new_pc_valid_o;
  logic [ADDR_W-1:0] new_pc_o;
  logic              mc_timeout_o;
  logic [1:0]        state_o;

  int checks = 0;
  int errors = 0;

  // Reference model: mode 0 running, 1 bubble just inserted, 2 waiting on EX.
  int              m_mode;
  int              m_waited;
  bit              m_pend;
  logic [ADDR_W-1:0] m_pend_addr;
  bit              m_timeout;

  pipe_ctrl #(.ADDR_W(ADDR_W), .MC_TIMEOUT(MC_TIMEOUT)) dut (
    .clk              (clk),
    .rst              (rst),
    .id_ld_use_i      (id_ld_use_i),
    .ex_mc_start_i    (ex_mc_start_i),
    .ex_mc_done_i     (ex_mc_done_i),
    .ex_branch_i      (ex_branch_i),
    .ex_branch_addr_i (ex_branch_addr_i),
    .mem_stall_i      (mem_stall_i),
    .stall_o          (stall_o),
    .flush_ifid_o     (flush_ifid_o),
    .flush_idex_o     (flush_idex_o),
    .flush_exmem_o    (flush_exmem_o),
    .new_pc_valid_o   (new_pc_valid_o),
    .new_pc_o         (new_pc_o),
    .mc_timeout_o     (mc_timeout_o),
    .state_o          (state_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: observed no finish, expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_expect(output logic [4:0] e_stall, output logic e_fifid,
                              output logic e_fidex, output logic e_fexmem,
                              output logic e_pcv, output logic [ADDR_W-1:0] e_pc);
    e_stall = 5'b0; e_fifid = 1'b0; e_fidex = 1'b0; e_fexmem = 1'b0;
    e_pcv = 1'b0; e_pc = '0;
    if (rst) return;
    if (mem_stall_i) begin
      e_stall = 5'b01111;
    end else if (m_mode == 2) begin
      if (!ex_mc_done_i) begin
        e_stall = 5'b00111; e_fexmem = 1'b1;
      end
    end else if (ex_mc_start_i) begin
      e_stall = 5'b00111; e_fexmem = 1'b1;
    end else if (ex_branch_i || m_pend) begin
      e_pcv = 1'b1; e_fifid = 1'b1; e_fidex = 1'b1;
      e_pc  = m_pend ? m_pend_addr : ex_branch_addr_i;
    end else if (id_ld_use_i && m_mode == 0) begin
      e_stall = 5'b00011; e_fidex = 1'b1;
    end
  endtask

  task automatic model_update();
    if (rst) begin
      m_mode = 0; m_waited = 0; m_pend = 0; m_pend_addr = '0; m_timeout = 0;
    end else if (mem_stall_i) begin
      if (ex_branch_i) begin
        m_pend = 1; m_pend_addr = ex_branch_addr_i;
      end
    end else if (m_mode == 2) begin
      if (ex_mc_done_i) m_mode = 0;
      else begin
        m_waited++;
        if (m_waited == MC_TIMEOUT) begin
          m_timeout = 1; m_mode = 0;
        end
      end
    end else if (ex_mc_start_i) begin
      m_mode = 2; m_waited = 0;
    end else if (ex_branch_i || m_pend) begin
      m_pend = 0; m_mode = 0;
    end else if (id_ld_use_i && m_mode == 0) begin
      m_mode = 1;
    end else begin
      m_mode = 0;
    end
  endtask

  task automatic sample(input string tag);
    logic [4:0]        e_stall;
    logic              e_fifid, e_fidex, e_fexmem, e_pcv;
    logic [ADDR_W-1:0] e_pc;
    @(negedge clk);
    model_expect(e_stall, e_fifid, e_fidex, e_fexmem, e_pcv, e_pc);
    chk({tag, ".stall"},       32'(stall_o),        32'(e_stall));
    chk({tag, ".flush_ifid"},  32'(flush_ifid_o),   32'(e_fifid));
    chk({tag, ".flush_idex"},  32'(flush_idex_o),   32'(e_fidex));
    chk({tag, ".flush_exmem"}, 32'(flush_exmem_o),  32'(e_fexmem));
    chk({tag, ".pc_valid"},    32'(new_pc_valid_o), 32'(e_pcv));
    chk({tag, ".new_pc"},      32'(new_pc_o),       32'(e_pc));
    chk({tag, ".timeout"},     32'(mc_timeout_o),   32'(m_timeout));
    chk({tag, ".state"},       32'(state_o),        32'(m_mode));
  endtask

  task automatic tick();
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic idle_inputs();
    id_ld_use_i = 0; ex_mc_start_i = 0; ex_mc_done_i = 0;
    ex_branch_i = 0; ex_branch_addr_i = '0; mem_stall_i = 0;
  endtask

  initial begin
    int n;
    m_mode = 0; m_waited = 0; m_pend = 0; m_pend_addr = '0; m_timeout = 0;
    idle_inputs();
    rst = 1;
    for (int i = 0; i < 3; i++) begin sample("reset"); tick(); end
    rst = 0;
    sample("post_reset");
    chk("reset_stall", 32'(stall_o), 32'h0);
    chk("reset_state", 32'(state_o), 32'h0);
    tick();

    // Reset arriving while waiting on a multi-cycle op
    ex_mc_start_i = 1; sample("t1_start"); tick();
    ex_mc_start_i = 0;
    for (int i = 0; i < 3; i++) begin sample("t1_wait"); tick(); end
    rst = 1;
    for (int i = 0; i < 3; i++) begin sample("t1_rst"); tick(); end
    rst = 0;
    sample("t1_after");
    chk("t1_state",   32'(state_o),      32'h0);
    chk("t1_stall",   32'(stall_o),      32'h0);
    chk("t1_timeout", 32'(mc_timeout_o), 32'h0);
    tick();

    // Load-use held for two cycles: exactly one bubble
    id_ld_use_i = 1;
    sample("t2_c0");
    chk("t2_c0_stall", 32'(stall_o),      32'h03);
    chk("t2_c0_fidex", 32'(flush_idex_o), 32'h1);
    tick();
    sample("t2_c1");
    chk("t2_c1_stall", 32'(stall_o),      32'h0);
    chk("t2_c1_fidex", 32'(flush_idex_o), 32'h0);
    tick();
    id_ld_use_i = 0;
    sample("t2_end");
    chk("t2_state", 32'(state_o), 32'h0);
    tick();

    // Multi-cycle op completing: start + 4 waits held, done cycle free
    ex_mc_start_i = 1;
    for (int i = 0; i < 5; i++) begin
      sample("t3_hold");
      chk("t3_hold_stall", 32'(stall_o),       32'h07);
      chk("t3_hold_fexm",  32'(flush_exmem_o), 32'h1);
      tick();
      ex_mc_start_i = 0;
    end
    ex_mc_done_i = 1;
    sample("t3_done");
    chk("t3_done_stall", 32'(stall_o),       32'h0);
    chk("t3_done_fexm",  32'(flush_exmem_o), 32'h0);
    tick();
    ex_mc_done_i = 0;
    sample("t3_run");
    chk("t3_run_state", 32'(state_o), 32'h0);

    // Multi-cycle op that never completes
    ex_mc_start_i = 1; tick();
    ex_mc_start_i = 0;
    n = 0;
    while (state_o == 2'd2 && n < 200) begin
      sample("t3_to_wait");
      tick();
      n++;
    end
    chk("t3_to_cycles", 32'(n), 32'(MC_TIMEOUT));
    sample("t3_to_end");
    chk("t3_to_flag",  32'(mc_timeout_o), 32'h1);
    chk("t3_to_state", 32'(state_o),      32'h0);
    tick();
    rst = 1; sample("t3_clr"); tick(); rst = 0;

    // Branch captured under memory wait, replayed on the first free cycle
    mem_stall_i = 1; ex_branch_i = 1; ex_branch_addr_i = 32'h80;
    for (int i = 0; i < 3; i++) begin
      if (i == 2) begin ex_branch_i = 0; ex_branch_addr_i = 32'h0; end
      sample("t4_stall");
      chk("t4_stall_vec", 32'(stall_o),        32'h0F);
      chk("t4_stall_pcv", 32'(new_pc_valid_o), 32'h0);
      tick();
    end
    mem_stall_i = 0;
    sample("t4_redir");
    chk("t4_pcv",   32'(new_pc_valid_o), 32'h1);
    chk("t4_pc",    32'(new_pc_o),       32'h80);
    chk("t4_fifid", 32'(flush_ifid_o),   32'h1);
    chk("t4_fidex", 32'(flush_idex_o),   32'h1);
    tick();

    // Branch wins over a same-cycle load-use
    ex_branch_i = 1; ex_branch_addr_i = 32'h100; id_ld_use_i = 1;
    sample("t5_br");
    chk("t5_pcv",   32'(new_pc_valid_o), 32'h1);
    chk("t5_pc",    32'(new_pc_o),       32'h100);
    chk("t5_stall", 32'(stall_o),        32'h0);
    tick();
    idle_inputs();
    sample("t5_after");
    chk("t5_state", 32'(state_o), 32'h0);
    tick();

    // Randomized traffic, avoiding combinations the core never produces
    for (int i = 0; i < 3000; i++) begin
      rst              = ($urandom_range(0, 149) == 0);
      mem_stall_i      = ($urandom_range(0, 4) == 0);
      id_ld_use_i      = ($urandom_range(0, 2) == 0);
      ex_branch_addr_i = $urandom;
      ex_branch_i      = (m_mode != 2 || mem_stall_i) && ($urandom_range(0, 5) == 0);
      ex_mc_start_i    = (m_mode == 0) && !ex_branch_i && ($urandom_range(0, 9) == 0);
      ex_mc_done_i     = (m_mode == 2) && ($urandom_range(0, (i < 1500) ? 7 : 99) == 0);
      sample("rnd");
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
